// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) / row-permutation helpers.
// Byte i of a 128-bit value sits at bits [127-8*i -: 8]; column c holds bytes 4c..4c+3.
package aes_pkg;

    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_SUB  = 2'd2;
    localparam logic [1:0] ST_UPD  = 2'd3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
        return o;
    endfunction

endpackage

// File: rtl/aes_mix_columns.sv
// Combinational MixColumns / InvMixColumns over all four columns, selected by inv_i.
module aes_mix_columns
    import aes_pkg::*;
(
    input  logic         inv_i,
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
                gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign state_o[127 - 32*c -: 32] = inv_i ? inv_mix_col(state_i[127 - 32*c -: 32])
                                                 : mix_col(state_i[127 - 32*c -: 32]);
    end

endmodule

// File: rtl/aes_core_iter.sv
// Iterative AES encipher/decipher core with external key schedule and shared S-boxes.
// Optional macro AES_CYCLE_CNT_EN adds an 8-bit saturating per-block cycle_count output.
module aes_core_iter
    import aes_pkg::*;
#(
    parameter int NR         = AES128_NR,
    parameter int SBOX_LANES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic                      mode,
    input  logic [127:0]              block,
    input  logic [127:0]              round_key,
    output logic [3:0]                round_idx,
    output logic [32*SBOX_LANES-1:0]  sboxw,
    input  logic [32*SBOX_LANES-1:0]  new_sboxw,
    input  logic [32*SBOX_LANES-1:0]  new_inv_sboxw,
    output logic [127:0]              result,
`ifdef AES_CYCLE_CNT_EN
    output logic [7:0]                cycle_count,
`endif
    output logic                      ready
);

    localparam int         SUB_CYCLES = 4 / SBOX_LANES;
    localparam logic [3:0] NR_L       = 4'(NR);

    logic [1:0]              fsm_q, fsm_d;
    logic                    mode_q, mode_d;
    logic [127:0]            state_q, state_d;
    logic [3:0]              rnd_q, rnd_d;
    logic [1:0]              wcnt_q, wcnt_d;
    logic [127:0]            result_q, result_d;
    logic [32*SBOX_LANES-1:0] sub_res;
    logic [127:0]            addkey, mix_in, mix_out, upd_state;
    logic                    last_round;

    assign last_round = (rnd_q == NR_L);
    assign sub_res    = mode_q ? new_inv_sboxw : new_sboxw;
    assign addkey     = state_q ^ round_key;

    // One MixColumns instance serves both directions: ShiftRows output when
    // enciphering, the key-added state when deciphering.
    assign mix_in = mode_q ? addkey : shift_rows(state_q);

    aes_mix_columns u_mix (
        .inv_i   (mode_q),
        .state_i (mix_in),
        .state_o (mix_out)
    );

    always_comb begin
        if (mode_q)
            upd_state = last_round ? addkey : inv_shift_rows(mix_out);
        else
            upd_state = (last_round ? mix_in : mix_out) ^ round_key;
    end

    always_comb begin
        round_idx = '0;
        if (fsm_q == ST_INIT)
            round_idx = mode_q ? NR_L : 4'd0;
        else if (fsm_q == ST_UPD)
            round_idx = mode_q ? NR_L - rnd_q : rnd_q;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        fsm_d    = fsm_q;
        mode_d   = mode_q;
        state_d  = state_q;
        rnd_d    = rnd_q;
        wcnt_d   = wcnt_q;
        result_d = result_q;
        sboxw    = '0;
        case (fsm_q)
            ST_IDLE: begin
                if (init) begin
                    fsm_d   = ST_INIT;
                    mode_d  = mode;
                    state_d = block;
                end
            end
            ST_INIT: begin
                state_d = mode_q ? inv_shift_rows(addkey) : addkey;
                rnd_d   = 4'd1;
                wcnt_d  = '0;
                fsm_d   = ST_SUB;
            end
            ST_SUB: begin
                // Lane 0 occupies the top 32 bits of sboxw; words go out w0 first.
                for (int w = 0; w < 4; w++) begin
                    if (wcnt_q == 2'(w / SBOX_LANES)) begin
                        sboxw[32*(SBOX_LANES-1-(w % SBOX_LANES)) +: 32] = state_q[32*(3-w) +: 32];
                        state_d[32*(3-w) +: 32] = sub_res[32*(SBOX_LANES-1-(w % SBOX_LANES)) +: 32];
                    end
                end
                if (wcnt_q == 2'(SUB_CYCLES - 1)) begin
                    wcnt_d = '0;
                    fsm_d  = ST_UPD;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            default: begin
                state_d = upd_state;
                if (last_round) begin
                    result_d = upd_state;
                    fsm_d    = ST_IDLE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                    fsm_d = ST_SUB;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            fsm_q    <= ST_IDLE;
            mode_q   <= 1'b0;
            state_q  <= '0;
            rnd_q    <= '0;
            wcnt_q   <= '0;
            result_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            mode_q   <= mode_d;
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            wcnt_q   <= wcnt_d;
            result_q <= result_d;
        end
    end

    assign ready  = (fsm_q == ST_IDLE);
    assign result = result_q;

`ifdef AES_CYCLE_CNT_EN
    logic [7:0] run_cnt_q, cycle_count_q;

    // run_cnt_q is 1 during INIT, so it equals the elapsed cycles when the last UPD retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q     <= '0;
            cycle_count_q <= '0;
        end else begin
            if (fsm_q == ST_IDLE) begin
                if (init)
                    run_cnt_q <= 8'd1;
            end else if (run_cnt_q != 8'hff) begin
                run_cnt_q <= run_cnt_q + 8'd1;
            end
            if (fsm_q == ST_UPD && last_round)
                cycle_count_q <= run_cnt_q;
        end
    end

    assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_aes_core_iter.sv
// Scoreboard bench for aes_core_iter: three instances (NR10/1 lane, NR10/4 lanes, NR14/1 lane)
// with behavioural key schedules and S-boxes; FIPS-197 vectors plus reset/busy/back-to-back cases.
module tb_aes_core_iter;

    logic clk;
    logic reset;

    logic         init_s   [3];
    logic         mode_s   [3];
    logic [127:0] block_s  [3];
    logic [127:0] rk_s     [3];
    logic [3:0]   ridx_s   [3];
    logic [127:0] result_s [3];
    logic         ready_s  [3];
`ifdef AES_CYCLE_CNT_EN
    logic [7:0]   cc_s     [3];
`endif

    logic [31:0]  sbw_a, new_a, inv_a;
    logic [127:0] sbw_b, new_b, inv_b;
    logic [31:0]  sbw_c, new_c, inv_c;

    logic [127:0] rk_tab [3][16];

    localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural GF(2^8) arithmetic for the S-box and key-schedule models.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = '0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        return t[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x;
        x = ginv(b);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return ginv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w, input logic inv);
        logic [31:0] o;
        for (int i = 0; i < 4; i++)
            o[8*i +: 8] = inv ? inv_sbox(w[8*i +: 8]) : sbox(w[8*i +: 8]);
        return o;
    endfunction

    task automatic expand_key(input int d, input logic [255:0] key, input int nk);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nw;
        nw   = 4 * (nk + 7);
        rcon = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}, 1'b0) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t, 1'b0);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    assign rk_s[0] = rk_tab[0][ridx_s[0]];
    assign rk_s[1] = rk_tab[1][ridx_s[1]];
    assign rk_s[2] = rk_tab[2][ridx_s[2]];

    always_comb begin
        new_a = sub_word(sbw_a, 1'b0);
        inv_a = sub_word(sbw_a, 1'b1);
        new_c = sub_word(sbw_c, 1'b0);
        inv_c = sub_word(sbw_c, 1'b1);
        new_b = '0;
        inv_b = '0;
        for (int k = 0; k < 4; k++) begin
            new_b[32*k +: 32] = sub_word(sbw_b[32*k +: 32], 1'b0);
            inv_b[32*k +: 32] = sub_word(sbw_b[32*k +: 32], 1'b1);
        end
    end

    aes_core_iter #(.NR(10), .SBOX_LANES(1)) u_dut (
        .clk(clk), .reset(reset), .init(init_s[0]), .mode(mode_s[0]), .block(block_s[0]),
        .round_key(rk_s[0]), .round_idx(ridx_s[0]), .sboxw(sbw_a), .new_sboxw(new_a),
        .new_inv_sboxw(inv_a), .result(result_s[0]),
`ifdef AES_CYCLE_CNT_EN
        .cycle_count(cc_s[0]),
`endif
        .ready(ready_s[0])
    );

    aes_core_iter #(.NR(10), .SBOX_LANES(4)) u_dut_l4 (
        .clk(clk), .reset(reset), .init(init_s[1]), .mode(mode_s[1]), .block(block_s[1]),
        .round_key(rk_s[1]), .round_idx(ridx_s[1]), .sboxw(sbw_b), .new_sboxw(new_b),
        .new_inv_sboxw(inv_b), .result(result_s[1]),
`ifdef AES_CYCLE_CNT_EN
        .cycle_count(cc_s[1]),
`endif
        .ready(ready_s[1])
    );

    aes_core_iter #(.NR(14), .SBOX_LANES(1)) u_dut_256 (
        .clk(clk), .reset(reset), .init(init_s[2]), .mode(mode_s[2]), .block(block_s[2]),
        .round_key(rk_s[2]), .round_idx(ridx_s[2]), .sboxw(sbw_c), .new_sboxw(new_c),
        .new_inv_sboxw(inv_c), .result(result_s[2]),
`ifdef AES_CYCLE_CNT_EN
        .cycle_count(cc_s[2]),
`endif
        .ready(ready_s[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int           dut;
        logic [127:0] res;
        int           lat;
        string        tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   edge_n = 0;
    logic mon_rst;
    logic rdy_prev  [3] = '{1'b1, 1'b1, 1'b1};
    int   acc_edge  [3] = '{0, 0, 0};
    int   done_edge [3] = '{0, 0, 0};
    int   acc_gap   [3] = '{0, 0, 0};
    int   acc_cnt   [3] = '{0, 0, 0};

    // Accept = ready falling without reset; completion = ready rising without reset.
    always @(posedge clk) begin
        edge_n++;
        mon_rst = reset;
        #1;
        for (int d = 0; d < 3; d++) begin
            if (mon_rst) begin
                for (int i = sb_q.size() - 1; i >= 0; i--)
                    if (sb_q[i].dut == d) sb_q.delete(i);
            end else begin
                if (rdy_prev[d] && !ready_s[d]) begin
                    acc_gap[d]  = edge_n - done_edge[d];
                    acc_edge[d] = edge_n;
                    acc_cnt[d]++;
                end
                if (!rdy_prev[d] && ready_s[d]) begin
                    done_edge[d] = edge_n;
                    check($sformatf("sb_pending_%0d", d), 128'(sb_q.size() > 0), 128'(1));
                    if (sb_q.size() > 0) begin
                        mon_e = sb_q.pop_front();
                        check({mon_e.tag, "_dut"}, 128'(d), 128'(mon_e.dut));
                        check({mon_e.tag, "_result"}, result_s[d], mon_e.res);
                        check({mon_e.tag, "_latency"}, 128'(edge_n - acc_edge[d]), 128'(mon_e.lat));
                    end
                end
            end
            rdy_prev[d] = ready_s[d];
        end
    end

    task automatic start_block(input int d, input logic m, input logic [127:0] blk,
                               input logic [127:0] res, input int lat, input string tag);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!ready_s[d] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_idle_before_start"}, 128'(ready_s[d]), 128'(1));
        sb_q.push_back('{d, res, lat, tag});
        init_s[d]  = 1'b1;
        mode_s[d]  = m;
        block_s[d] = blk;
        @(negedge clk);
        init_s[d] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 128'(sb_q.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            init_s[d]  = 1'b0;
            mode_s[d]  = 1'b0;
            block_s[d] = '0;
        end
        expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand_key(1, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        expand_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        repeat (3) @(negedge clk);

        check("rst_ready", 128'(ready_s[0]), 128'(1));
        check("rst_result", result_s[0], 128'(0));
        check("rst_round_idx", 128'(ridx_s[0]), 128'(0));
        check("rst_sboxw", 128'(sbw_a), 128'(0));
        check("rst_ready_l4", 128'(ready_s[1]), 128'(1));
        check("rst_result_256", result_s[2], 128'(0));
        reset = 1'b0;

        start_block(0, 1'b0, PT_C, CT_C1, 51, "c1_enc");
        drain(200);
`ifdef AES_CYCLE_CNT_EN
        check("cycle_count_c1", 128'(cc_s[0]), 128'(51));
`endif
        start_block(0, 1'b1, CT_C1, PT_C, 51, "c1_dec");
        drain(200);

        start_block(1, 1'b0, PT_B, CT_B, 21, "appb_l4_enc");
        drain(200);

        start_block(2, 1'b0, PT_C, CT_C3, 71, "c3_enc");
        drain(200);
        start_block(2, 1'b1, CT_C3, PT_C, 71, "c3_dec");
        drain(200);

        // Init pulse mid-block must not disturb the block in flight or the held result.
        start_block(0, 1'b0, PT_C, CT_C1, 51, "busy_enc");
        repeat (15) @(negedge clk);
        init_s[0]  = 1'b1;
        mode_s[0]  = 1'b1;
        block_s[0] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        init_s[0] = 1'b0;
        check("busy_ready_low", 128'(ready_s[0]), 128'(0));
        check("busy_result_hold", result_s[0], PT_C);
        drain(200);

        // Reset during round 5 aborts the block and clears the result.
        start_block(0, 1'b1, CT_C1, PT_C, 51, "abort_dec");
        repeat (22) @(negedge clk);
        check("abort_busy", 128'(ready_s[0]), 128'(0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", 128'(ready_s[0]), 128'(1));
        check("abort_result", result_s[0], 128'(0));
        check("abort_round_idx", 128'(ridx_s[0]), 128'(0));
        check("abort_flushed", 128'(sb_q.size()), 128'(0));
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 128'(ready_s[0]), 128'(1));

        // init held high: second block accepted on the first ready cycle.
        base = acc_cnt[0];
        sb_q.push_back('{0, CT_C1, 51, "b2b_first"});
        sb_q.push_back('{0, PT_C, 51, "b2b_second"});
        @(negedge clk);
        init_s[0]  = 1'b1;
        mode_s[0]  = 1'b0;
        block_s[0] = PT_C;
        n = 0;
        while (acc_cnt[0] < base + 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        mode_s[0]  = 1'b1;
        block_s[0] = CT_C1;
        n = 0;
        while (acc_cnt[0] < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        init_s[0] = 1'b0;
        check("b2b_accepts", 128'(acc_cnt[0] - base), 128'(2));
        check("b2b_accept_gap", 128'(acc_gap[0]), 128'(1));
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
